// File: rtl/divider_pkg.sv
// Shared definitions for the sequential restoring divider: operand width,
// iteration counter width, FSM state encoding and two's complement helpers.
package divider_pkg;

  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Two's complement negation at operand width.
  function automatic logic [WIDTH-1:0] neg_val(input logic [WIDTH-1:0] v);
    return (~v) + 1'b1;
  endfunction

  // Magnitude of a two's complement operand; -2^(WIDTH-1) maps onto itself,
  // which is the correct unsigned magnitude.
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? neg_val(v) : v;
  endfunction

endpackage

// File: rtl/divider_step.sv
// One combinational restoring-division iteration: shift the next dividend
// bit into the partial remainder, trial-subtract the divisor, and keep the
// difference only when it does not go negative.
module divider_step
  import divider_pkg::*;
(
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH:0]   next_rem,
  output logic [WIDTH-1:0] next_quo
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;
  logic           unused_rem_msb;

  // The partial remainder always stays below the divisor, so its top bit
  // never carries information into the shift.
  assign unused_rem_msb = rem[WIDTH];

  // Trial subtraction; a set MSB means the divisor did not fit.
  always_comb begin
    shifted  = {rem[WIDTH-1:0], quo[WIDTH-1]};
    trial    = shifted - {1'b0, dvs};
    next_rem = trial[WIDTH] ? shifted : trial;
    next_quo = {quo[WIDTH-2:0], ~trial[WIDTH]};
  end

endmodule

// File: rtl/divider.sv
// Sequential restoring divider, one quotient bit per clock, with the same
// start/busy/done handshake as the shift-add multiplier.
// Build option: define DIVIDER_SIGNED_EN for two's complement operands
// (truncating toward zero); left undefined the block is unsigned only.
module divider
  import divider_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             start_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_by_zero_o
);

  state_t           state;
  logic [WIDTH:0]   rem_reg;
  logic [WIDTH-1:0] quo_reg;
  logic [WIDTH-1:0] dvs_reg;
  logic [CNT_W-1:0] count;
  logic             dbz_reg;

  logic [WIDTH:0]   step_rem;
  logic [WIDTH-1:0] step_quo;
  logic [WIDTH-1:0] load_dividend;
  logic [WIDTH-1:0] load_divisor;
  logic [WIDTH-1:0] final_quo;
  logic [WIDTH-1:0] final_rem;

  divider_step u_step (
    .rem      (rem_reg),
    .quo      (quo_reg),
    .dvs      (dvs_reg),
    .next_rem (step_rem),
    .next_quo (step_quo)
  );

`ifdef DIVIDER_SIGNED_EN
  logic neg_quo_reg;
  logic neg_rem_reg;

  // The core always works on magnitudes; signs are restored at completion.
  always_comb begin
    load_dividend = abs_val(dividend_i);
    load_divisor  = abs_val(divisor_i);
    final_quo     = neg_quo_reg ? neg_val(quo_reg) : quo_reg;
    final_rem     = neg_rem_reg ? neg_val(rem_reg[WIDTH-1:0]) : rem_reg[WIDTH-1:0];
  end

  // Capture the sign information on the accepted start.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      neg_quo_reg <= 1'b0;
      neg_rem_reg <= 1'b0;
    end else if (state == IDLE && start_i) begin
      neg_quo_reg <= dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1];
      neg_rem_reg <= dividend_i[WIDTH-1];
    end
  end
`else
  // Unsigned build: operands and results pass straight through.
  always_comb begin
    load_dividend = dividend_i;
    load_divisor  = divisor_i;
    final_quo     = quo_reg;
    final_rem     = rem_reg[WIDTH-1:0];
  end
`endif

  assign busy_o = (state == RUN);

  // Control FSM and datapath: accept, iterate WIDTH times, then publish.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state         <= IDLE;
      rem_reg       <= '0;
      quo_reg       <= '0;
      dvs_reg       <= '0;
      count         <= '0;
      dbz_reg       <= 1'b0;
      quotient_o    <= '0;
      remainder_o   <= '0;
      done_o        <= 1'b0;
      div_by_zero_o <= 1'b0;
    end else begin
      done_o        <= 1'b0;
      div_by_zero_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            if (divisor_i == '0) begin
              quo_reg <= dividend_i;
              dbz_reg <= 1'b1;
              state   <= DONE;
            end else begin
              rem_reg <= '0;
              quo_reg <= load_dividend;
              dvs_reg <= load_divisor;
              count   <= '0;
              dbz_reg <= 1'b0;
              state   <= RUN;
            end
          end
        end
        RUN: begin
          if (count < CNT_W'(WIDTH)) begin
            rem_reg <= step_rem;
            quo_reg <= step_quo;
            count   <= count + 1'b1;
          end else begin
            state <= DONE;
          end
        end
        DONE: begin
          done_o <= 1'b1;
          if (dbz_reg) begin
            quotient_o    <= '1;
            remainder_o   <= quo_reg;
            div_by_zero_o <= 1'b1;
          end else begin
            quotient_o  <= final_quo;
            remainder_o <= final_rem;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for the restoring divider: stimulus pushes expected
// results, a monitor pops and compares on every done_o pulse.
module tb_divider;
  import divider_pkg::*;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic [WIDTH-1:0] dividend_i;
  logic [WIDTH-1:0] divisor_i;
  logic             start_i;
  logic [WIDTH-1:0] quotient_o;
  logic [WIDTH-1:0] remainder_o;
  logic             busy_o;
  logic             done_o;
  logic             div_by_zero_o;

  typedef struct {
    int q;
    int r;
    int dbz;
    int accept_edge;
    int lat;
    int busy;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   edge_cnt = 0;
  int   busy_cnt = 0;
  bit   rst_edge = 1'b0;

  divider dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .dividend_i    (dividend_i),
    .divisor_i     (divisor_i),
    .start_i       (start_i),
    .quotient_o    (quotient_o),
    .remainder_o   (remainder_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .div_by_zero_o (div_by_zero_o)
  );

  always #5 clk_i = ~clk_i;

  // Edge counter for latency checks, plus a note of reset at each edge.
  always @(posedge clk_i) begin
    edge_cnt <= edge_cnt + 1;
    rst_edge <= !rst_ni;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Monitor: counts busy cycles and checks each completion against the queue.
  always @(negedge clk_i) begin
    exp_t e;
    if (rst_edge) busy_cnt = 0;
    if (busy_o === 1'b1) busy_cnt++;
    if (done_o === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        checkOutput("quotient", int'(quotient_o), e.q);
        checkOutput("remainder", int'(remainder_o), e.r);
        checkOutput("div_by_zero", int'(div_by_zero_o), e.dbz);
        checkOutput("latency", edge_cnt - e.accept_edge, e.lat);
        checkOutput("busy_cycles", busy_cnt, e.busy);
      end
      busy_cnt = 0;
    end
  end

  task automatic applyStimulus(input int a, input int b, input int q, input int r,
                               input int dbz, input int lat, input int busy);
    @(negedge clk_i);
    dividend_i = WIDTH'(a);
    divisor_i  = WIDTH'(b);
    start_i    = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    sb.push_back('{q, r, dbz, edge_cnt, lat, busy});
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk_i);
    if (sb.size() != 0) begin
      checkOutput("completion_timeout", sb.size(), 0);
      sb.delete();
    end
    repeat (2) @(negedge clk_i);
  endtask

  initial begin
    int n;
    int seen;

    rst_ni     = 1'b0;
    start_i    = 1'b0;
    dividend_i = '0;
    divisor_i  = '0;
    repeat (2) @(negedge clk_i);
    checkOutput("rst_quotient", int'(quotient_o), 0);
    checkOutput("rst_remainder", int'(remainder_o), 0);
    checkOutput("rst_done", int'(done_o), 0);
    checkOutput("rst_dbz", int'(div_by_zero_o), 0);
    checkOutput("rst_busy", int'(busy_o), 0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Basic unsigned vectors.
    applyStimulus(100, 7, 14, 2, 0, 10, 9);     waitIdle();
    applyStimulus(255, 1, 255, 0, 0, 10, 9);    waitIdle();
    applyStimulus(5, 9, 0, 5, 0, 10, 9);        waitIdle();
    applyStimulus(200, 200, 1, 0, 0, 10, 9);    waitIdle();
    applyStimulus(13, 0, 255, 13, 1, 1, 0);     waitIdle();

    // A start pulse during RUN must be ignored.
    applyStimulus(100, 7, 14, 2, 0, 10, 9);
    repeat (2) @(negedge clk_i);
    dividend_i = 8'd50;
    divisor_i  = 8'd5;
    start_i    = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    waitIdle();
    repeat (3) @(negedge clk_i);

    // start_i held high: second op accepted on the first cycle back in IDLE.
    dividend_i = 8'd100;
    divisor_i  = 8'd7;
    start_i    = 1'b1;
    @(negedge clk_i);
    n = edge_cnt;
    sb.push_back('{14, 2, 0, n, 10, 9});
    dividend_i = 8'd50;
    divisor_i  = 8'd5;
    sb.push_back('{10, 0, 0, n + 11, 10, 9});
    seen = 0;
    for (int i = 0; i < 30 && seen == 0; i++) begin
      @(negedge clk_i);
      if (done_o === 1'b1) seen = 1;
    end
    checkOutput("held_first_done_seen", seen, 1);
    @(negedge clk_i);
    start_i = 1'b0;
    waitIdle();

    // Reset in the middle of RUN aborts without a done pulse.
    @(negedge clk_i);
    dividend_i = 8'd100;
    divisor_i  = 8'd7;
    start_i    = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b0;
    @(negedge clk_i);
    checkOutput("abort_quotient", int'(quotient_o), 0);
    checkOutput("abort_remainder", int'(remainder_o), 0);
    checkOutput("abort_done", int'(done_o), 0);
    checkOutput("abort_dbz", int'(div_by_zero_o), 0);
    checkOutput("abort_busy", int'(busy_o), 0);
    rst_ni = 1'b1;
    seen = 0;
    repeat (14) begin
      @(negedge clk_i);
      if (done_o === 1'b1) seen = 1;
    end
    checkOutput("abort_no_done", seen, 0);
    applyStimulus(9, 2, 4, 1, 0, 10, 9);        waitIdle();

`ifdef DIVIDER_SIGNED_EN
    // Signed vectors (truncation toward zero, wrap on overflow).
    applyStimulus(8'h9C, 7, 8'hF2, 8'hFE, 0, 10, 9);     waitIdle();
    applyStimulus(100, 8'hF9, 8'hF2, 2, 0, 10, 9);       waitIdle();
    applyStimulus(8'h80, 8'hFF, 8'h80, 0, 0, 10, 9);     waitIdle();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
